mandel_iterator: RTL and testbench



---
 rtl/mandel_pkg.sv | 22 ++
 rtl/fxp_mul.sv | 17 +
 rtl/mandel_iterator.sv | 163 ++++++++++++++++
 tb/tb_mandel_iterator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot escape-time engine.
// All complex values travel as signed Q11.21; squared terms are Q22.42.
package mandel_pkg;

    localparam int FRAC_BITS = 21;
    localparam int FXP_W     = 32;
    localparam int PROD_W    = 2 * FXP_W;
    localparam int MAG_W     = PROD_W + 2;

    // 4.0 in Q22.42, widened so the sum of two squares can be compared directly
    localparam logic [MAG_W-1:0] ESCAPE_R2 = MAG_W'(4) << (2 * FRAC_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic signed [FXP_W-1:0]  q11_21_t;
    typedef logic signed [PROD_W-1:0] q22_42_t;

endpackage

// File: rtl/fxp_mul.sv
// Combinational full-precision signed multiply: Q11.21 x Q11.21 -> Q22.42.
module fxp_mul
    import mandel_pkg::*;
(
    input  q11_21_t i_a,
    input  q11_21_t i_b,
    output q22_42_t o_p
);

    q22_42_t w_a;
    q22_42_t w_b;

    assign w_a = q22_42_t'(i_a);
    assign w_b = q22_42_t'(i_b);
    assign o_p = w_a * w_b;

endmodule

// File: rtl/mandel_iterator.sv
// Escape-time engine: iterates z <- z^2 + c from zero, one step per cycle,
// and hands the iteration count plus pixel coordinates downstream.
module mandel_iterator
    import mandel_pkg::*;
#(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_real,
    input  logic [31:0]       in_ims,
    input  logic [31:0]       in_x,
    input  logic [31:0]       in_y,
    input  logic              in_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_count,
    output logic [31:0]       out_x,
    output logic [31:0]       out_y,
    output logic              out_ovf
);

    state_t r_state;
    state_t w_nextState;

    q11_21_t           r_cr;
    q11_21_t           r_ci;
    q11_21_t           r_zr;
    q11_21_t           r_zi;
    logic [ITER_W-1:0] r_n;
    logic [31:0]       r_inX;
    logic [31:0]       r_inY;
    logic              r_inOvf;

    logic [ITER_W-1:0] r_count;
    logic [31:0]       r_outX;
    logic [31:0]       r_outY;
    logic              r_outOvf;

    q22_42_t           w_zr2;
    q22_42_t           w_zi2;
    q22_42_t           w_zrzi;
    q22_42_t           w_diff;
    logic [MAG_W-1:0]  w_mag2;
    logic              w_escape;
    logic              w_atCap;
    logic              w_accept;
    logic              w_finish;
    logic              w_release;
    q11_21_t           w_zrNext;
    q11_21_t           w_ziNext;
    logic              w_unusedBits;

    fxp_mul u_mulRr (
        .i_a (r_zr),
        .i_b (r_zr),
        .o_p (w_zr2)
    );

    fxp_mul u_mulIi (
        .i_a (r_zi),
        .i_b (r_zi),
        .o_p (w_zi2)
    );

    fxp_mul u_mulRi (
        .i_a (r_zr),
        .i_b (r_zi),
        .o_p (w_zrzi)
    );

    // Squares are non-negative, so zero-extension gives the exact unsigned sum
    assign w_mag2   = {2'b00, w_zr2} + {2'b00, w_zi2};
    assign w_escape = (w_mag2 > ESCAPE_R2);
    assign w_atCap  = (r_n == ITER_W'(MAX_ITER));

    assign w_diff   = w_zr2 - w_zi2;
    // The doubling of zr*zi is folded into the slice position
    assign w_zrNext = q11_21_t'(w_diff[FRAC_BITS+FXP_W-1:FRAC_BITS]) + r_cr;
    assign w_ziNext = q11_21_t'(w_zrzi[FRAC_BITS+FXP_W-2:FRAC_BITS-1]) + r_ci;

    assign w_unusedBits = ^{w_diff[PROD_W-1:FRAC_BITS+FXP_W], w_diff[FRAC_BITS-1:0],
                            w_zrzi[PROD_W-1:FRAC_BITS+FXP_W-1], w_zrzi[FRAC_BITS-2:0]};

    assign w_accept  = in_valid & in_ready;
    assign w_finish  = (r_state == ITER) & (w_escape | w_atCap);
    assign w_release = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_nextState = ITER;
            ITER:    if (w_finish)  w_nextState = DONE;
            DONE:    if (w_release) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cr    <= '0;
            r_ci    <= '0;
            r_zr    <= '0;
            r_zi    <= '0;
            r_n     <= '0;
            r_inX   <= '0;
            r_inY   <= '0;
            r_inOvf <= 1'b0;
        end else if (w_accept) begin
            r_cr    <= q11_21_t'(in_real);
            r_ci    <= q11_21_t'(in_ims);
            r_zr    <= '0;
            r_zi    <= '0;
            r_n     <= '0;
            r_inX   <= in_x;
            r_inY   <= in_y;
            r_inOvf <= in_ovf;
        end else if ((r_state == ITER) && !w_finish) begin
            r_zr <= w_zrNext;
            r_zi <= w_ziNext;
            r_n  <= r_n + 1'b1;
        end
    end

    // Result registers move only when a point leaves ITER, so they stay
    // frozen for the whole of DONE regardless of backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_outX   <= '0;
            r_outY   <= '0;
            r_outOvf <= 1'b0;
        end else if (w_finish) begin
            r_count  <= r_n;
            r_outX   <= r_inX;
            r_outY   <= r_inY;
            r_outOvf <= r_inOvf;
        end
    end

    assign out_count = r_count;
    assign out_x     = r_outX;
    assign out_y     = r_outY;
    assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_mandel_iterator.sv
// Self-checking bench for mandel_iterator: directed corner points plus
// random points compared against a plain-arithmetic escape-time model.
module tb_mandel_iterator;

    localparam int MAX_ITER = 255;
    localparam int ITER_W   = 8;
    localparam int TIMEOUT  = 600;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_real = '0;
    logic [31:0]       in_ims = '0;
    logic [31:0]       in_x = '0;
    logic [31:0]       in_y = '0;
    logic              in_ovf = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ITER_W-1:0] out_count;
    logic [31:0]       out_x;
    logic [31:0]       out_y;
    logic              out_ovf;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    mandel_iterator #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_ims    (in_ims),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_ovf   (out_ovf)
    );

    // Escape-time count straight from the iteration rule, in wide integers
    function automatic int modelCount(input int cr, input int ci);
        longint      zr;
        longint      zi;
        longint      prr;
        longint      pii;
        longint      pri;
        logic [127:0] mag;
        int          nr;
        int          ni;
        zr = 0;
        zi = 0;
        for (int n = 0; n <= MAX_ITER; n++) begin
            prr = zr * zr;
            pii = zi * zi;
            pri = zr * zi;
            mag = 128'(prr) + 128'(pii);
            if (mag > (128'd4 << 42) || n == MAX_ITER) return n;
            nr = int'((prr - pii) >>> 21) + cr;
            ni = int'((2 * pri) >>> 21) + ci;
            zr = longint'(nr);
            zi = longint'(ni);
        end
        return MAX_ITER;
    endfunction

    // Present a point at a falling edge, wait for acceptance, then count
    // rising edges from the accept edge until out_valid is seen.
    task automatic sendPoint(input logic [31:0] cr, input logic [31:0] ci,
                             input logic [31:0] x, input logic [31:0] y,
                             input logic ovf, output int lat, output bit timedOut);
        int k;
        @(negedge clk);
        in_real  = cr;
        in_ims   = ci;
        in_x     = x;
        in_y     = y;
        in_ovf   = ovf;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        timedOut = !out_valid;
    endtask

    task automatic collect();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        else nPass++;
        nChecks++;
        if (out_count !== '0 || out_x !== '0 || out_y !== '0 || out_ovf !== 1'b0)
            $display("[TB] FAIL reset_outputs: count=%0d x=%0d y=%0d ovf=%b, want all 0",
                     out_count, out_x, out_y, out_ovf);
        else nPass++;
        rst = 1'b0;
    endtask

    task automatic test_directed(input string name, input logic [31:0] cr, input logic [31:0] ci,
                                 input int expCount);
        int lat;
        bit to;
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom;
        y = $urandom;
        sendPoint(cr, ci, x, y, 1'b1, lat, to);
        nChecks++;
        if (to || out_count !== ITER_W'(expCount) || lat != expCount + 1)
            $display("[TB] FAIL %s: count=%0d lat=%0d timeout=%b, want count=%0d lat=%0d",
                     name, out_count, lat, to, expCount, expCount + 1);
        else nPass++;
        nChecks++;
        if (out_x !== x || out_y !== y || out_ovf !== 1'b1)
            $display("[TB] FAIL %s_pass: x=%h y=%h ovf=%b, want x=%h y=%h ovf=1",
                     name, out_x, out_y, out_ovf, x, y);
        else nPass++;
        collect();
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        bit stable;
        sendPoint(32'h0000_0000, 32'h0020_0000, 32'd100, 32'd200, 1'b0, lat, to);
        nChecks++;
        if (to || out_count !== ITER_W'(MAX_ITER) || lat != MAX_ITER + 1)
            $display("[TB] FAIL c_i_count: count=%0d lat=%0d, want count=%0d lat=%0d",
                     out_count, lat, MAX_ITER, MAX_ITER + 1);
        else nPass++;
        in_real  = 32'h0060_0000;
        in_x     = 32'd999;
        in_valid = 1'b1;
        stable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== ITER_W'(MAX_ITER) ||
                out_x !== 32'd100 || out_y !== 32'd200 || out_ovf !== 1'b0)
                stable = 1'b0;
        end
        nChecks++;
        if (!stable)
            $display("[TB] FAIL backpressure_hold: valid=%b ready=%b count=%0d x=%0d y=%0d, want 1/0/%0d/100/200",
                     out_valid, in_ready, out_count, out_x, out_y, MAX_ITER);
        else nPass++;
        in_valid = 1'b0;
        collect();
        nChecks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        sendPoint(32'h0060_0000, 32'h0, 32'd5, 32'd7, 1'b0, lat, to);
        nChecks++;
        if (to || out_count !== 8'd1 || out_x !== 32'd5 || out_y !== 32'd7 || out_ovf !== 1'b0)
            $display("[TB] FAIL b2b_first: count=%0d x=%0d y=%0d ovf=%b, want 1/5/7/0",
                     out_count, out_x, out_y, out_ovf);
        else nPass++;
        // Offer the second point in the same cycle as the first handshake
        in_real   = 32'h0020_0000;
        in_ims    = 32'h0;
        in_x      = 32'd6;
        in_y      = 32'd7;
        in_ovf    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        nChecks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL b2b_no_early_accept: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        else nPass++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        nChecks++;
        if (!out_valid || out_count !== 8'd3 || lat != 4 || out_x !== 32'd6 || out_y !== 32'd7 || out_ovf !== 1'b1)
            $display("[TB] FAIL b2b_second: valid=%b count=%0d lat=%0d x=%0d y=%0d ovf=%b, want 1/3/4/6/7/1",
                     out_valid, out_count, lat, out_x, out_y, out_ovf);
        else nPass++;
        collect();
    endtask

    task automatic test_reset_mid_iter();
        int lat;
        bit to;
        @(negedge clk);
        in_real  = 32'h0;
        in_ims   = 32'h0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0)
            $display("[TB] FAIL reset_abort: out_valid=%b in_ready=%b count=%0d, want 0/1/0",
                     out_valid, in_ready, out_count);
        else nPass++;
        @(negedge clk);
        rst = 1'b0;
        sendPoint(32'h0060_0000, 32'h0, 32'd1, 32'd2, 1'b0, lat, to);
        nChecks++;
        if (to || out_count !== 8'd1 || lat != 2)
            $display("[TB] FAIL reset_recover: count=%0d lat=%0d, want 1/2", out_count, lat);
        else nPass++;
        collect();
    endtask

    task automatic test_random();
        int lat;
        bit to;
        int cr;
        int ci;
        int exp;
        logic [31:0] x;
        logic [31:0] y;
        logic ovf;
        for (int i = 0; i < 20; i++) begin
            cr  = int'($urandom_range(32'h00A0_0000, 0)) - 32'sh0050_0000;
            ci  = int'($urandom_range(32'h0060_0000, 0)) - 32'sh0030_0000;
            x   = $urandom;
            y   = $urandom;
            ovf = 1'($urandom_range(1, 0));
            exp = modelCount(cr, ci);
            sendPoint(cr, ci, x, y, ovf, lat, to);
            nChecks++;
            if (to || out_count !== ITER_W'(exp) || lat != exp + 1 ||
                out_x !== x || out_y !== y || out_ovf !== ovf)
                $display("[TB] FAIL random_%0d c=(%h,%h): count=%0d lat=%0d x=%h y=%h ovf=%b, want %0d/%0d/%h/%h/%b",
                         i, cr, ci, out_count, lat, out_x, out_y, out_ovf, exp, exp + 1, x, y, ovf);
            else nPass++;
            repeat ($urandom_range(3, 0)) @(negedge clk);
            collect();
        end
    endtask

    initial begin
        test_reset();
        test_directed("c_3", 32'h0060_0000, 32'h0, 1);
        test_directed("c_1", 32'h0020_0000, 32'h0, 3);
        test_directed("c_m2_strict", 32'hFFC0_0000, 32'h0, MAX_ITER);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_iter();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
